// File: rtl/aes_key_reverser_if.sv
// rtl/aes_key_reverser_if.sv - start/key-load request and round-key stream bundle for aes_key_reverser
interface aes_key_reverser_if;
  logic         start;
  logic [127:0] last_key;
  logic [127:0] round_key;
  logic [3:0]   round_idx;
  logic         key_valid;
  logic         key_ready;
  logic         busy;
  logic         done;

  modport master (
    output start, last_key, key_ready,
    input  round_key, round_idx, key_valid, busy, done
  );

  modport slave (
    input  start, last_key, key_ready,
    output round_key, round_idx, key_valid, busy, done
  );
endinterface

// File: rtl/aes_key_reverser.sv
// rtl/aes_key_reverser.sv - AES-128 reverse key schedule, streams K10..K0 one round per cycle
// Optional AES_KEY_REVERSER_EQINV_EN: InvMixColumns on output keys 1..9 for the equivalent inverse cipher.
module aes_key_reverser #(
  parameter int NR = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  aes_key_reverser_if.slave kif
);

  if (NR != 10) begin : g_nr_check
    $error("aes_key_reverser: only NR=10 (AES-128) is supported");
  end

  localparam logic [2047:0] SBOX_TBL = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  typedef enum logic {IDLE, EMIT} state_e;

  function automatic logic [7:0] sbox(input logic [7:0] x);
    return SBOX_TBL[2047 - 8*int'(x) -: 8];
  endfunction

  function automatic logic [31:0] sub_word(input logic [31:0] x);
    return {sbox(x[31:24]), sbox(x[23:16]), sbox(x[15:8]), sbox(x[7:0])};
  endfunction

  // Index 0 never reaches the datapath; it decodes to zero.
  function automatic logic [7:0] rcon(input logic [3:0] r);
    case (r)
      4'd1:    return 8'h01;
      4'd2:    return 8'h02;
      4'd3:    return 8'h04;
      4'd4:    return 8'h08;
      4'd5:    return 8'h10;
      4'd6:    return 8'h20;
      4'd7:    return 8'h40;
      4'd8:    return 8'h80;
      4'd9:    return 8'h1b;
      4'd10:   return 8'h36;
      default: return 8'h00;
    endcase
  endfunction

  state_e       state_q, state_d;
  logic [127:0] cur_key_q, cur_key_d;
  logic [3:0]   round_idx_q, round_idx_d;
  logic         key_valid_q, key_valid_d;
  logic         busy_q, busy_d;
  logic         done_q, done_d;

  logic [31:0]  a0, a1, a2, a3, b0, b1, b2, b3;
  logic [127:0] prev_key;

  assign a0 = cur_key_q[127:96];
  assign a1 = cur_key_q[95:64];
  assign a2 = cur_key_q[63:32];
  assign a3 = cur_key_q[31:0];
  assign b3 = a3 ^ a2;
  assign b2 = a2 ^ a1;
  assign b1 = a1 ^ a0;
  assign b0 = a0 ^ sub_word({b3[23:0], b3[31:24]}) ^ {rcon(round_idx_q), 24'h0};
  assign prev_key = {b0, b1, b2, b3};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cur_key_q   <= '0;
      round_idx_q <= '0;
      key_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_key_q   <= cur_key_d;
      round_idx_q <= round_idx_d;
      key_valid_q <= key_valid_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cur_key_d   = cur_key_q;
    round_idx_d = round_idx_q;
    key_valid_d = key_valid_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    case (state_q)
      IDLE: begin
        if (kif.start) begin
          cur_key_d   = kif.last_key;
          round_idx_d = 4'(NR);
          key_valid_d = 1'b1;
          busy_d      = 1'b1;
          state_d     = EMIT;
        end
      end
      EMIT: begin
        if (kif.key_ready) begin
          if (round_idx_q != 4'd0) begin
            cur_key_d   = prev_key;
            round_idx_d = round_idx_q - 4'd1;
          end else begin
            key_valid_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            state_d     = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

`ifdef AES_KEY_REVERSER_EQINV_EN
  function automatic logic [7:0] xt(input logic [7:0] x);
    return {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic logic [31:0] inv_mix_col(input logic [31:0] c);
    logic [7:0] s [4];
    logic [7:0] m2 [4];
    logic [7:0] m4 [4];
    logic [7:0] m8 [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    for (int i = 0; i < 4; i++) begin
      s[i]  = c[31-8*i -: 8];
      m2[i] = xt(s[i]);
      m4[i] = xt(m2[i]);
      m8[i] = xt(m4[i]);
      m9[i] = m8[i] ^ s[i];
      mb[i] = m8[i] ^ m2[i] ^ s[i];
      md[i] = m8[i] ^ m4[i] ^ s[i];
      me[i] = m8[i] ^ m4[i] ^ m2[i];
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  logic [127:0] round_key_eq;

  // The cur_key chain stays raw; only the presented key is transformed.
  always_comb begin
    round_key_eq = cur_key_q;
    if (round_idx_q != 4'd0 && round_idx_q != 4'(NR)) begin
      round_key_eq = {inv_mix_col(a0), inv_mix_col(a1), inv_mix_col(a2), inv_mix_col(a3)};
    end
  end

  assign kif.round_key = round_key_eq;
`else
  assign kif.round_key = cur_key_q;
`endif

  assign kif.round_idx = round_idx_q;
  assign kif.key_valid = key_valid_q;
  assign kif.busy      = busy_q;
  assign kif.done      = done_q;

endmodule
